// File: rtl/half_band_decim_mux_pkg.sv
// Shared constants and helpers for the half-band decimator.
// Taps are -1, 9, 16, 9, -1 at delays 0, 2, 3, 4, 6. The 9 taps are built as
// (v << SIDE_SHIFT) + v and the 16 tap as v << CTR_SHIFT. RND is the rounding
// constant added before the OUT_SHIFT arithmetic right shift.
package half_band_decim_mux_pkg;

  localparam int SIDE_SHIFT = 3;  // 9 = 8 + 1
  localparam int CTR_SHIFT  = 4;  // 16
  localparam int RND        = 8;
  localparam int OUT_SHIFT  = 4;

  // Clip v to [-2**w, 2**w - 1]. Operates on 32-bit ints, so the accumulator
  // width (dw+7) must not exceed 32.
  function automatic int sat_clip(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << w) - 1;
    lo = -(1 << w);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/half_band_decim_mux_reg_delay.sv
// Gated shift register of len words, dw bits each.
// Ports: clk, rst (sync, active high), gate (shift enable), din, dout (len-deep).
module half_band_decim_mux_reg_delay #(
  parameter int dw  = 16,
  parameter int len = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gate,
  input  logic [dw-1:0] din,
  output logic [dw-1:0] dout
);

  logic [dw-1:0] line_q [len];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < len; i++) line_q[i] <= '0;
    end else if (gate) begin
      line_q[0] <= din;
      for (int i = 1; i < len; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign dout = line_q[len-1];

endmodule

// File: rtl/half_band_decim_mux.sv
// Half-band low-pass filter and 2:1 decimator for nch time-interleaved channels.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   iv         input strobe, x valid this cycle
//   x          signed input sample, channels in order 0..nch-1
//   phase_sel  0 keeps even frames, 1 keeps odd frames (sampled at frame start)
//   ov         output strobe, 4 clk after the iv cycle of the kept sample
//   och        channel index of d
//   d          signed filtered, decimated, saturated sample (dw+1 bits)
module half_band_decim_mux
  import half_band_decim_mux_pkg::*;
#(
  parameter int dw  = 16,
  parameter int nch = 2,
  parameter int cw  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iv,
  input  logic signed [dw-1:0] x,
  input  logic                 phase_sel,
  output logic                 ov,
  output logic [cw-1:0]        och,
  output logic signed [dw:0]   d
);

  localparam int aw = dw + 7;

  // Channel counter, frame parity and the phase held for the current frame.
  logic [cw-1:0] chan_q, chan_d;
  logic          par_q, par_d;
  logic          ph_q, ph_d;
  logic          frame_start, last_ch, keep;

  assign frame_start = (chan_q == '0);
  assign last_ch     = (chan_q == cw'(nch - 1));
  // At frame start the live phase_sel applies; afterwards the latched copy.
  assign keep        = (par_q == (frame_start ? phase_sel : ph_q));

  always_comb begin
    chan_d = chan_q;
    par_d  = par_q;
    ph_d   = ph_q;
    if (iv) begin
      if (frame_start) ph_d = phase_sel;
      if (last_ch) begin
        chan_d = '0;
        par_d  = ~par_q;
      end else begin
        chan_d = chan_q + cw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_q <= '0;
      par_q  <= 1'b0;
      ph_q   <= 1'b0;
    end else begin
      chan_q <= chan_d;
      par_q  <= par_d;
      ph_q   <= ph_d;
    end
  end

  // History: taps[k] is the same channel's sample k frames back.
  logic signed [dw-1:0] taps [7];
  assign taps[0] = x;

  for (genvar gi = 0; gi < 6; gi++) begin : g_hist
    half_band_decim_mux_reg_delay #(.dw(dw), .len(nch)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .gate (iv),
      .din  (taps[gi]),
      .dout (taps[gi+1])
    );
  end

  logic signed [aw-1:0] x0e, x2e, x3e, x4e, x6e;
  assign x0e = aw'(taps[0]);
  assign x2e = aw'(taps[2]);
  assign x3e = aw'(taps[3]);
  assign x4e = aw'(taps[4]);
  assign x6e = aw'(taps[6]);

  // Three-stage adder pipeline plus output register.
  logic                 v1_q, v2_q, v3_q, ov_q;
  logic [cw-1:0]        ch1_q, ch2_q, ch3_q, och_q;
  logic signed [aw-1:0] p1_end_q, p1_side_q, p1_ctr_q;
  logic signed [aw-1:0] p2_end_q, p2_side_q, p2_ctr_q;
  logic signed [aw-1:0] p3_q;
  logic signed [dw:0]   d_q, d_sat;

  assign d_sat = (dw+1)'(sat_clip(int'(p3_q), dw));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      ov_q      <= 1'b0;
      ch1_q     <= '0;
      ch2_q     <= '0;
      ch3_q     <= '0;
      och_q     <= '0;
      p1_end_q  <= '0;
      p1_side_q <= '0;
      p1_ctr_q  <= '0;
      p2_end_q  <= '0;
      p2_side_q <= '0;
      p2_ctr_q  <= '0;
      p3_q      <= '0;
      d_q       <= '0;
    end else begin
      // Pre-add the symmetric pairs; the outer pair carries the -1 tap.
      v1_q      <= iv & keep;
      ch1_q     <= chan_q;
      p1_end_q  <= -(x0e + x6e);
      p1_side_q <= x2e + x4e;
      p1_ctr_q  <= x3e;
      // Scale by 9 and 16 with shifts; fold rounding into the outer pair.
      v2_q      <= v1_q;
      ch2_q     <= ch1_q;
      p2_end_q  <= p1_end_q + aw'(RND);
      p2_side_q <= (p1_side_q <<< SIDE_SHIFT) + p1_side_q;
      p2_ctr_q  <= p1_ctr_q <<< CTR_SHIFT;
      // Final sum, floor divide by 16.
      v3_q      <= v2_q;
      ch3_q     <= ch2_q;
      p3_q      <= (p2_end_q + p2_side_q + p2_ctr_q) >>> OUT_SHIFT;
      // Output register holds its value between strobes.
      ov_q      <= v3_q;
      if (v3_q) begin
        och_q <= ch3_q;
        d_q   <= d_sat;
      end
    end
  end

  assign ov  = ov_q;
  assign och = och_q;
  assign d   = d_q;

endmodule

// File: tb/tb_half_band_decim_mux.sv
module tb_half_band_decim_mux;

  localparam int NI = 3;  // instances with nch = 2, 3, 4

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NI-1:0]        iv_a, ps_a, ov_a;
  logic [NI-1:0][15:0]  x_a;
  logic [NI-1:0][3:0]   och_a;
  logic [NI-1:0][16:0]  d_a;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    half_band_decim_mux #(.dw(16), .nch(gi + 2), .cw(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .iv        (iv_a[gi]),
      .x         (x_a[gi]),
      .phase_sel (ps_a[gi]),
      .ov        (ov_a[gi]),
      .och       (och_a[gi]),
      .d         (d_a[gi])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int hist [NI][16][7];
  int m_chan [NI];
  int m_par  [NI];
  int m_ph   [NI];
  int e_v  [NI][4];
  int e_ch [NI][4];
  int e_d  [NI][4];
  int last_ch [NI];
  int last_d  [NI];

  int log_k = 0;
  int log_ch[$];
  int log_d[$];

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got %0d expected %0d", nm, k, cyc, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input int ech, input int ed);
    if (idx >= log_ch.size()) begin
      checks++;
      errors++;
      $display("FAIL %s missing output %0d (have %0d) expected ch %0d d %0d",
               nm, idx, log_ch.size(), ech, ed);
    end else begin
      chk({nm, "_ch"}, log_k, log_ch[idx], ech);
      chk({nm, "_d"}, log_k, log_d[idx], ed);
    end
  endtask

  // Model: per-channel sample history; outputs come out 4 cycles later.
  initial begin
    int n, c, acc, q;
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < NI; k++) begin
        n = k + 2;
        for (int s = 3; s > 0; s--) begin
          e_v[k][s]  = e_v[k][s-1];
          e_ch[k][s] = e_ch[k][s-1];
          e_d[k][s]  = e_d[k][s-1];
        end
        e_v[k][0] = 0;
        if (rst) begin
          for (int cc = 0; cc < 16; cc++)
            for (int j = 0; j < 7; j++) hist[k][cc][j] = 0;
          m_chan[k] = 0;
          m_par[k]  = 0;
          m_ph[k]   = 0;
          for (int s = 0; s < 4; s++) e_v[k][s] = 0;
          last_ch[k] = 0;
          last_d[k]  = 0;
        end else if (iv_a[k]) begin
          c = m_chan[k];
          if (c == 0) m_ph[k] = ps_a[k];
          for (int j = 6; j > 0; j--) hist[k][c][j] = hist[k][c][j-1];
          hist[k][c][0] = $signed(x_a[k]);
          acc = -hist[k][c][0] + 9 * hist[k][c][2] + 16 * hist[k][c][3]
                + 9 * hist[k][c][4] - hist[k][c][6] + 8;
          q = acc >>> 4;
          if (q > 65535) q = 65535;
          if (q < -65536) q = -65536;
          if (m_par[k] == m_ph[k]) begin
            e_v[k][0]  = 1;
            e_ch[k][0] = c;
            e_d[k][0]  = q;
          end
          m_chan[k] = m_chan[k] + 1;
          if (m_chan[k] == n) begin
            m_chan[k] = 0;
            m_par[k]  = 1 - m_par[k];
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (e_v[k][3] != 0) begin
          chk("ov", k, int'(ov_a[k]), 1);
          chk("och", k, int'(och_a[k]), e_ch[k][3]);
          chk("d", k, int'($signed(d_a[k])), e_d[k][3]);
          last_ch[k] = e_ch[k][3];
          last_d[k]  = e_d[k][3];
        end else begin
          chk("ov", k, int'(ov_a[k]), 0);
          chk("och_hold", k, int'(och_a[k]), last_ch[k]);
          chk("d_hold", k, int'($signed(d_a[k])), last_d[k]);
        end
        if (ov_a[k] && k == log_k) begin
          log_ch.push_back(int'(och_a[k]));
          log_d.push_back(int'($signed(d_a[k])));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    iv_a = '0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    iv_a = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input int k, input int v, input int p);
    iv_a[k] = 1'b1;
    x_a[k]  = 16'(v);
    ps_a[k] = p[0];
    step();
  endtask

  task automatic start_log(input int k);
    log_k = k;
    log_ch.delete();
    log_d.delete();
  endtask

  int t1_exp [4] = '{-62, 563, 563, -62};
  int t2_exp [3] = '{0, 1000, 0};
  int t4_pat [7] = '{-32768, 0, 32767, 32767, 32767, 0, -32768};

  initial begin
    rst  = 1'b1;
    iv_a = '0;
    ps_a = '0;
    x_a  = '0;
    step();
    step();
    // Reset state
    chk("reset_ov", 0, int'(ov_a[0]), 0);
    chk("reset_och", 0, int'(och_a[0]), 0);
    chk("reset_d", 0, int'($signed(d_a[0])), 0);
    rst = 1'b0;

    // 1: nch=2, phase 0, impulse on ch0 frame 0
    do_reset();
    start_log(0);
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 2; c++) push(0, (f == 0 && c == 0) ? 1000 : 0, 0);
    idle(8);
    chk("t1_count", 0, log_ch.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chk_log("t1_ch0", 2 * i, 0, t1_exp[i]);
      chk_log("t1_ch1", 2 * i + 1, 1, 0);
    end

    // 2: same stimulus, phase 1
    do_reset();
    start_log(0);
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 2; c++) push(0, (f == 0 && c == 0) ? 1000 : 0, 1);
    idle(8);
    chk("t2_count", 0, log_ch.size(), 8);
    for (int i = 0; i < 3; i++) begin
      chk_log("t2_ch0", 2 * i, 0, t2_exp[i]);
      chk_log("t2_ch1", 2 * i + 1, 1, 0);
    end

    // 3: nch=3, constant full-scale inputs
    do_reset();
    start_log(1);
    for (int i = 0; i < 24; i++) push(1, 32767, 0);
    idle(8);
    for (int c = 0; c < 3; c++) chk_log("t3_pos", 9 + c, c, 65534);
    do_reset();
    start_log(1);
    for (int i = 0; i < 24; i++) push(1, -32768, 0);
    idle(8);
    for (int c = 0; c < 3; c++) chk_log("t3_neg", 9 + c, c, -65536);

    // 4: saturation patterns on ch0
    do_reset();
    start_log(0);
    for (int f = 0; f < 7; f++) begin
      push(0, t4_pat[f], 0);
      push(0, 0, 0);
    end
    idle(8);
    chk_log("t4_pos", 6, 0, 65535);
    do_reset();
    start_log(0);
    for (int f = 0; f < 7; f++) begin
      push(0, (t4_pat[f] == 0) ? 0 : -1 - t4_pat[f], 0);
      push(0, 0, 0);
    end
    idle(8);
    chk_log("t4_neg", 6, 0, -65536);

    // 5: nch=4, random gaps, data and phase_sel
    do_reset();
    for (int i = 0; i < 400; i++) begin
      iv_a[2] = ($urandom_range(0, 99) >= 40);
      x_a[2]  = 16'($urandom);
      ps_a[2] = 1'($urandom_range(0, 1));
      step();
    end
    idle(8);

    // 6: reset with results in flight
    do_reset();
    push(0, 5000, 0);
    push(0, -3000, 0);
    push(0, 7000, 0);
    rst     = 1'b1;
    iv_a[0] = 1'b1;
    x_a[0]  = 16'(12345);
    step();
    rst  = 1'b0;
    iv_a = '0;
    chk("t6_ov_after_rst", 0, int'(ov_a[0]), 0);
    chk("t6_d_after_rst", 0, int'($signed(d_a[0])), 0);
    start_log(0);
    push(0, 1000, 0);
    push(0, 0, 0);
    idle(8);
    chk_log("t6_first", 0, 0, -62);
    chk_log("t6_second", 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
